// File: rtl/thread_sched_n_if.sv
// Scheduler <-> core signal bundle: thread requests and weight programming in,
// context-switch controls and the current thread/credit out.
interface thread_sched_n_if #(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = 2,
    parameter int CREDIT_W    = 11,
    parameter int FRAC_W      = 5
);
    logic [NUM_THREADS-1:0] thread_ready;
    logic                   wt_wr_en;
    logic [TID_W-1:0]       wt_wr_tid;
    logic [FRAC_W-1:0]      wt_wr_data;
    logic                   pause_mult;
    logic                   thread_giveup;
    logic [TID_W-1:0]       thread_id;
    logic                   context_save;
    logic                   context_restore;
    logic                   freeze_proc;
    logic                   lock_pipeline;
    logic                   detachmem;
    logic                   idle;
    logic [CREDIT_W-1:0]    cur_credit;

    // Core side: raises requests, consumes switch controls.
    modport master (
        output thread_ready, wt_wr_en, wt_wr_tid, wt_wr_data, pause_mult, thread_giveup,
        input  thread_id, context_save, context_restore, freeze_proc, lock_pipeline,
               detachmem, idle, cur_credit
    );

    // Scheduler side.
    modport slave (
        input  thread_ready, wt_wr_en, wt_wr_tid, wt_wr_data, pause_mult, thread_giveup,
        output thread_id, context_save, context_restore, freeze_proc, lock_pipeline,
               detachmem, idle, cur_credit
    );
endinterface

// File: rtl/thread_sched_n.sv
// Credit-weighted thread scheduler and context-switch sequencer for the yf32
// multithreaded core: per-thread fixed-point credits pick the next context.
module thread_sched_n #(
    parameter int NUM_THREADS    = 4,
    parameter int TID_W          = 2,
    parameter int CREDIT_W       = 11,
    parameter int FRAC_W         = 5,
    parameter int INIT_CREDIT    = 256,
    parameter int MAX_CREDIT     = 512,
    parameter int PREEMPT_THRESH = 20,
    parameter int DEFAULT_WEIGHT = 8,
    parameter int RESTORE_CYCLES = 5,
    parameter int CALM_CYCLES    = 4
) (
    input logic             clk,
    input logic             reset,
    thread_sched_n_if.slave bus
);
    localparam int VEC_W   = CREDIT_W + FRAC_W;
    localparam int CNT_MAX = (RESTORE_CYCLES > CALM_CYCLES) ? RESTORE_CYCLES : CALM_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_INIT, S_EXEC, S_WAITPAUSE, S_FREEZE, S_SAVE,
        S_DETACH, S_SELECT, S_RESTORE, S_CALM
    } state_t;

    state_t              state, state_nx;
    logic [TID_W-1:0]    tid_q, tid_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [VEC_W-1:0]    vec    [NUM_THREADS];
    logic [FRAC_W-1:0]   weight [NUM_THREADS];
    logic [TID_W-1:0]    sel_tid;
    logic                sel_found;
    logic [CREDIT_W-1:0] best;
    logic [CREDIT_W-1:0] cur_cr;
    logic                none_ready;
    logic                preempt;

    // Running thread pays one credit per cycle and earns its weight back;
    // waiting threads earn their weight up to the saturation ceiling.
    function automatic logic [VEC_W-1:0] next_vec(input logic [VEC_W-1:0]  v,
                                                  input logic [FRAC_W-1:0] wt,
                                                  input logic              running);
        logic [VEC_W:0] sum;
        logic [VEC_W:0] ceil_v;
        ceil_v = (VEC_W+1)'(MAX_CREDIT) << FRAC_W;
        sum    = {1'b0, v} + (VEC_W+1)'(wt);
        if (running) begin
            if (v[VEC_W-1:FRAC_W] != '0)
                next_vec = VEC_W'(sum - (VEC_W+1)'(1 << FRAC_W));
            else
                next_vec = sum[VEC_W-1:0];
        end else if (v[VEC_W-1:FRAC_W] < CREDIT_W'(MAX_CREDIT)) begin
            next_vec = (sum > ceil_v) ? ceil_v[VEC_W-1:0] : sum[VEC_W-1:0];
        end else begin
            next_vec = v;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                vec[i]    <= VEC_W'(INIT_CREDIT) << FRAC_W;
                weight[i] <= FRAC_W'(DEFAULT_WEIGHT);
            end
        end else begin
            for (int i = 0; i < NUM_THREADS; i++)
                vec[i] <= next_vec(vec[i], weight[i], TID_W'(i) == tid_q);
            if (bus.wt_wr_en)
                weight[bus.wt_wr_tid] <= bus.wt_wr_data;
        end
    end

    // Highest integer credit among ready threads; strict compare keeps the lowest index on ties.
    always_comb begin
        sel_tid   = '0;
        sel_found = 1'b0;
        best      = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (bus.thread_ready[i] && (!sel_found || vec[i][VEC_W-1:FRAC_W] > best)) begin
                sel_found = 1'b1;
                best      = vec[i][VEC_W-1:FRAC_W];
                sel_tid   = TID_W'(i);
            end
        end
    end

    assign none_ready = ~|bus.thread_ready;
    assign cur_cr     = vec[tid_q][VEC_W-1:FRAC_W];
    assign preempt    = (cur_cr <= CREDIT_W'(PREEMPT_THRESH)) | bus.thread_giveup
                        | ~bus.thread_ready[tid_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_INIT;
            tid_q <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            tid_q <= tid_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tid_nx   = tid_q;
        cnt_nx   = cnt;
        case (state)
            S_INIT:      state_nx = S_EXEC;
            S_EXEC:      if (preempt) state_nx = S_WAITPAUSE;
            S_WAITPAUSE: if (!bus.pause_mult) state_nx = S_FREEZE;
            S_FREEZE:    state_nx = S_SAVE;
            S_SAVE:      state_nx = S_DETACH;
            S_DETACH:    state_nx = S_SELECT;
            S_SELECT: begin
                if (!none_ready) begin
                    tid_nx   = sel_tid;
                    cnt_nx   = '0;
                    state_nx = S_RESTORE;
                end
            end
            S_RESTORE: begin
                if (cnt == CNT_W'(RESTORE_CYCLES - 1)) begin
                    cnt_nx   = '0;
                    state_nx = S_CALM;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_CALM: begin
                if (cnt == CNT_W'(CALM_CYCLES - 1)) begin
                    cnt_nx   = '0;
                    state_nx = S_EXEC;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default:     state_nx = S_WAITPAUSE;
        endcase
    end

    // Reset masks the decode so an interrupted switch cannot leak a save/restore pulse.
    always_comb begin
        bus.freeze_proc     = 1'b1;
        bus.lock_pipeline   = 1'b1;
        bus.detachmem       = 1'b0;
        bus.context_save    = 1'b0;
        bus.context_restore = 1'b0;
        bus.idle            = 1'b0;
        if (!reset) begin
            case (state)
                S_EXEC: begin
                    bus.freeze_proc   = 1'b0;
                    bus.lock_pipeline = 1'b0;
                end
                S_SAVE:   bus.context_save = 1'b1;
                S_DETACH: bus.detachmem    = 1'b1;
                S_SELECT: begin
                    bus.detachmem = 1'b1;
                    bus.idle      = none_ready;
                end
                S_RESTORE: begin
                    bus.detachmem       = 1'b1;
                    bus.context_restore = 1'b1;
                    bus.lock_pipeline   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.thread_id  = tid_q;
    assign bus.cur_credit = cur_cr;
endmodule

// File: tb/tb_thread_sched_n.sv
// Directed bench for thread_sched_n: expected output records are queued as
// stimulus is applied and compared cycle by cycle as the scheduler responds.
module tb_thread_sched_n;
    logic clk = 1'b0;
    logic reset;

    thread_sched_n_if #(.NUM_THREADS(4), .TID_W(2), .CREDIT_W(11), .FRAC_W(5)) bus ();

    thread_sched_n dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam int S_INIT = 0, S_EXEC = 1, S_WAIT = 2, S_FREEZE = 3, S_SAVE = 4, S_DETACH = 5,
                   S_SELECT = 6, S_IDLE = 7, S_RESTORE = 8, S_CALM = 9;
    // Record: {idle, detachmem, lock, freeze, restore, save, thread_id[1:0], cur_credit[10:0]}
    localparam logic [18:0] M_ALL = 19'h7FFFF;
    localparam logic [18:0] M_CTL = 19'h7F800;

    typedef struct {
        string       tag;
        logic [18:0] exp;
        logic [18:0] mask;
    } sb_t;

    sb_t sbq[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  n           = 0;
    int  sw_seq[15]  = '{S_WAIT, S_FREEZE, S_SAVE, S_DETACH, S_SELECT,
                         S_RESTORE, S_RESTORE, S_RESTORE, S_RESTORE, S_RESTORE,
                         S_CALM, S_CALM, S_CALM, S_CALM, S_EXEC};

    function automatic logic [18:0] ex(input int s, input logic [1:0] tid, input logic [10:0] cr);
        logic idl, det, lck, frz, rst_o, sav;
        idl = 1'b0; det = 1'b0; lck = 1'b1; frz = 1'b1; rst_o = 1'b0; sav = 1'b0;
        case (s)
            S_EXEC:    begin lck = 1'b0; frz = 1'b0; end
            S_SAVE:    sav = 1'b1;
            S_DETACH:  det = 1'b1;
            S_SELECT:  det = 1'b1;
            S_IDLE:    begin det = 1'b1; idl = 1'b1; end
            S_RESTORE: begin det = 1'b1; rst_o = 1'b1; lck = 1'b0; end
            default: ;
        endcase
        return {idl, det, lck, frz, rst_o, sav, tid, cr};
    endfunction

    // Thread running since release with weight 8: loses 24/32 credit per cycle.
    function automatic logic [10:0] run_cr(input int cyc);
        return 11'((8192 - 24 * cyc) / 32);
    endfunction

    function automatic logic [18:0] obs();
        return {bus.idle, bus.detachmem, bus.lock_pipeline, bus.freeze_proc,
                bus.context_restore, bus.context_save, bus.thread_id, bus.cur_credit};
    endfunction

    task automatic push(input string tag, input int s, input logic [1:0] tid,
                        input logic [10:0] cr, input logic [18:0] mask);
        sb_t e;
        e.tag  = tag;
        e.exp  = ex(s, tid, cr);
        e.mask = mask;
        sbq.push_back(e);
    endtask

    task automatic check_now();
        sb_t         e;
        logic [18:0] o;
        vectors++;
        if (sbq.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty observed=%h expected=<queued record>", obs());
        end else begin
            e = sbq.pop_front();
            o = obs();
            assert ((o & e.mask) === (e.exp & e.mask)) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h (n=%0d)", e.tag, o & e.mask,
                       e.exp & e.mask, n);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic tick_check();
        tick();
        check_now();
    endtask

    task automatic drain();
        while (sbq.size() > 0) tick_check();
    endtask

    task automatic do_reset(input logic [3:0] rdy);
        reset              = 1'b1;
        bus.thread_ready   = rdy;
        bus.wt_wr_en       = 1'b0;
        bus.wt_wr_tid      = 2'd0;
        bus.wt_wr_data     = 5'd0;
        bus.pause_mult     = 1'b0;
        bus.thread_giveup  = 1'b0;
        tick();
        tick();
        push("reset_state", S_INIT, 2'd0, 11'd256, M_ALL);
        check_now();
        reset = 1'b0;
        n     = 0;
    endtask

    initial begin
        // Self-switch on giveup: full 14-cycle sequence, thread 0 reselected.
        do_reset(4'b0001);
        push("t1_exec", S_EXEC, 2'd0, run_cr(1), M_ALL);
        push("t1_exec", S_EXEC, 2'd0, run_cr(2), M_ALL);
        drain();
        bus.thread_giveup = 1'b1;
        for (int k = 0; k < 15; k++) push("t1_switch", sw_seq[k], 2'd0, run_cr(3 + k), M_ALL);
        tick_check();
        bus.thread_giveup = 1'b0;
        drain();

        // Ready 0110 with all credits tied: thread 1 wins.
        do_reset(4'b0110);
        push("t2_exec", S_EXEC, 2'd0, run_cr(1), M_ALL);
        for (int k = 0; k < 15; k++) begin
            int c;
            c = 2 + k;
            if (c >= 7)
                push("t2_switch", sw_seq[k], 2'd1, 11'((8248 - 24 * (c - 7)) / 32), M_ALL);
            else
                push("t2_switch", sw_seq[k], 2'd0, run_cr(c), M_ALL);
        end
        drain();

        // No thread ready: hold SELECT idle, then thread 3 arrives.
        do_reset(4'b0001);
        push("t3_exec", S_EXEC, 2'd0, run_cr(1), M_ALL);
        drain();
        bus.thread_ready = 4'b0000;
        push("t3_wait",   S_WAIT,   2'd0, run_cr(2), M_ALL);
        push("t3_freeze", S_FREEZE, 2'd0, run_cr(3), M_ALL);
        push("t3_save",   S_SAVE,   2'd0, run_cr(4), M_ALL);
        push("t3_detach", S_DETACH, 2'd0, run_cr(5), M_ALL);
        for (int c = 6; c <= 8; c++) push("t3_idle", S_IDLE, 2'd0, run_cr(c), M_ALL);
        drain();
        bus.thread_ready = 4'b1000;
        #1;
        push("t3_select_ready", S_SELECT, 2'd0, run_cr(8), M_ALL);
        check_now();
        for (int k = 5; k < 15; k++) push("t3_to_thread3", sw_seq[k], 2'd3, 11'd0, M_CTL);
        drain();

        // Multiplier busy for 10 cycles delays the freeze.
        do_reset(4'b0001);
        push("t4_exec", S_EXEC, 2'd0, run_cr(1), M_ALL);
        drain();
        bus.thread_giveup = 1'b1;
        bus.pause_mult    = 1'b1;
        for (int c = 2; c <= 10; c++) push("t4_waitpause", S_WAIT, 2'd0, run_cr(c), M_ALL);
        tick_check();
        bus.thread_giveup = 1'b0;
        drain();
        bus.pause_mult = 1'b0;
        for (int k = 1; k < 15; k++) push("t4_switch", sw_seq[k], 2'd0, run_cr(10 + k), M_ALL);
        drain();

        // Credit drain of the running thread to the preempt threshold, then saturation of thread 3.
        do_reset(4'b0001);
        for (int c = 1; c <= 315; c++)
            push("t5_drain", (c <= 314) ? S_EXEC : S_WAIT, 2'd0, run_cr(c), M_ALL);
        drain();
        for (int i = 0; i < 800; i++) tick();
        bus.thread_ready = 4'b1000;
        for (int i = 0; i < 60; i++) begin
            if (bus.thread_id == 2'd3) break;
            tick();
        end
        push("t5_sat_512", S_RESTORE, 2'd3, 11'd512, M_ALL);
        check_now();
        push("t5_sat_run", S_RESTORE, 2'd3, 11'd511, M_ALL);
        tick_check();

        // Weight write to 0 for idle thread 2; write-cycle accounting still uses weight 8.
        do_reset(4'b0001);
        for (int c = 1; c <= 3; c++) push("t6_exec", S_EXEC, 2'd0, run_cr(c), M_ALL);
        drain();
        bus.wt_wr_en     = 1'b1;
        bus.wt_wr_tid    = 2'd2;
        bus.wt_wr_data   = 5'd0;
        bus.thread_ready = 4'b0100;
        push("t6_wait", S_WAIT, 2'd0, run_cr(4), M_ALL);
        tick_check();
        bus.wt_wr_en = 1'b0;
        push("t6_freeze", S_FREEZE, 2'd0, run_cr(5), M_ALL);
        push("t6_save",   S_SAVE,   2'd0, run_cr(6), M_ALL);
        push("t6_detach", S_DETACH, 2'd0, run_cr(7), M_ALL);
        push("t6_select", S_SELECT, 2'd0, run_cr(8), M_ALL);
        push("t6_frozen_cr",  S_RESTORE, 2'd2, 11'd257, M_ALL);
        push("t6_run_w0_a",   S_RESTORE, 2'd2, 11'd256, M_ALL);
        push("t6_run_w0_b",   S_RESTORE, 2'd2, 11'd255, M_ALL);
        drain();

        // Reset landing on the SAVE cycle suppresses the pulse.
        do_reset(4'b0001);
        push("t7_exec", S_EXEC, 2'd0, run_cr(1), M_ALL);
        drain();
        bus.thread_giveup = 1'b1;
        push("t7_wait", S_WAIT, 2'd0, run_cr(2), M_ALL);
        tick_check();
        bus.thread_giveup = 1'b0;
        push("t7_freeze", S_FREEZE, 2'd0, run_cr(3), M_ALL);
        push("t7_save",   S_SAVE,   2'd0, run_cr(4), M_ALL);
        drain();
        reset = 1'b1;
        #1;
        push("t7_rst_in_save", S_INIT, 2'd0, 11'd0, M_CTL);
        check_now();
        push("t7_rst_init", S_INIT, 2'd0, 11'd256, M_ALL);
        tick_check();
        reset = 1'b0;
        n     = 0;
        push("t7_after_rst", S_EXEC, 2'd0, run_cr(1), M_ALL);
        push("t7_after_rst", S_EXEC, 2'd0, run_cr(2), M_ALL);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end
endmodule
